// File: rtl/mul_div_if.sv
// Issue/result bundle between MIPS control/register file and the HI/LO mul/div unit.
interface mul_div_if;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, a, b, input busy, done, hi, lo);
    modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit owning the MIPS HI/LO registers.
// Shift-add multiply and restoring divide on magnitudes, sign fixed up on the final write.
module mul_div_unit (
    input  logic      clk,
    input  logic      rst,
    mul_div_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t      state;
    logic [4:0]  cnt;
    logic        is_div;
    logic        neg_res;
    logic        neg_rem;
    logic        div_zero;
    logic [31:0] a_orig;
    logic [31:0] opnd;
    logic [63:0] acc;
    logic [31:0] rem;

    logic        sgn_op;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [32:0] mul_sum;
    logic [32:0] rem_shift;
    logic [32:0] div_diff;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        sgn_op    = ~bus.op[0];
        mag_a     = (sgn_op && bus.a[31]) ? -bus.a : bus.a;
        mag_b     = (sgn_op && bus.b[31]) ? -bus.b : bus.b;
        // Multiplier bits sit in acc[31:0] and shift out as the product shifts in.
        mul_sum   = {1'b0, acc[63:32]} + {1'b0, (acc[0] ? opnd : 32'd0)};
        // Dividend bits shift out of acc[31:0] while quotient bits shift in.
        rem_shift = {rem, acc[31]};
        div_diff  = rem_shift - {1'b0, opnd};
        prod_fix  = neg_res ? -acc : acc;
        quo_fix   = neg_res ? -acc[31:0] : acc[31:0];
        rem_fix   = neg_rem ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 5'd0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.hi   <= 32'd0;
            bus.lo   <= 32'd0;
            // NOTE: datapath registers are reset too so a mid-RUN abort leaves no stale partial result.
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            a_orig   <= 32'd0;
            opnd     <= 32'd0;
            acc      <= 64'd0;
            rem      <= 32'd0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (!bus.op[2]) begin
                            state    <= RUN;
                            bus.busy <= 1'b1;
                            cnt      <= 5'd0;
                            is_div   <= bus.op[1];
                            neg_res  <= sgn_op && (bus.a[31] ^ bus.b[31]);
                            neg_rem  <= sgn_op && bus.a[31];
                            div_zero <= (bus.b == 32'd0);
                            a_orig   <= bus.a;
                            acc      <= {32'd0, (bus.op[1] ? mag_a : mag_b)};
                            opnd     <= bus.op[1] ? mag_b : mag_a;
                            rem      <= 32'd0;
                        end else if (bus.op == OP_MTHI) begin
                            bus.hi <= bus.a;
                        end else if (bus.op == OP_MTLO) begin
                            bus.lo <= bus.a;
                        end
                    end
                end
                RUN: begin
                    if (is_div) begin
                        if (!div_diff[32]) begin
                            rem       <= div_diff[31:0];
                            acc[31:0] <= {acc[30:0], 1'b1};
                        end else begin
                            rem       <= rem_shift[31:0];
                            acc[31:0] <= {acc[30:0], 1'b0};
                        end
                    end else begin
                        acc <= {mul_sum, acc[31:1]};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= DONE;
                end
                DONE: begin
                    // 0x80000000 / -1 needs no special case: negating 0x80000000 wraps to itself.
                    if (!is_div) begin
                        {bus.hi, bus.lo} <= prod_fix;
                    end else if (div_zero) begin
                        bus.hi <= a_orig;
                        bus.lo <= 32'hFFFF_FFFF;
                    end else begin
                        bus.hi <= rem_fix;
                        bus.lo <= quo_fix;
                    end
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed HI/LO results, latency, stall and reset behaviour.
module tb_mul_div_unit;
    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass   = 0;

    mul_div_if bus ();

    mul_div_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Issues one mul/div op, optionally pokes a second start at iteration poke_at,
    // then waits for done and checks latency, hold behaviour and the final HI/LO.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int poke_at,
                         input logic [2:0] poke_op);
        int          lat;
        logic        held;
        logic        busy_ok;
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0     = bus.hi;
        lo0     = bus.lo;
        held    = 1'b1;
        busy_ok = 1'b1;
        lat     = 0;
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 32'hA5A5_A5A5;
        bus.b     = 32'h5A5A_5A5A;
        check({tag, " busy_after_issue"}, 64'(bus.busy), 64'd1);
        check({tag, " done_after_issue"}, 64'(bus.done), 64'd0);
        while (!bus.done && lat < 40) begin
            if (poke_at > 0 && lat == poke_at) begin
                bus.start = 1'b1;
                bus.op    = poke_op;
                bus.a     = 32'd2;
                bus.b     = 32'd2;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (!bus.done && (bus.hi !== hi0 || bus.lo !== lo0)) held = 1'b0;
            if (!bus.done && !bus.busy) busy_ok = 1'b0;
        end
        bus.start = 1'b0;
        check({tag, " latency"}, 64'(lat), 64'd33);
        check({tag, " hilo_held"}, 64'(held), 64'd1);
        check({tag, " busy_during_run"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
        check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0;
        bus.op    = MULTU;
        bus.a     = 32'd0;
        bus.b     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset hi", 64'(bus.hi), 64'd0);
        check("reset lo", 64'(bus.lo), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // MTHI then MTLO on consecutive cycles.
        bus.start = 1'b1;
        bus.op    = MTHI;
        bus.a     = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("mthi hi", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        check("mthi lo_untouched", 64'(bus.lo), 64'd0);
        check("mthi busy", 64'(bus.busy), 64'd0);
        bus.op = MTLO;
        bus.a  = 32'h0BAD_F00D;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("mtlo lo", 64'(bus.lo), 64'h0000_0000_0BAD_F00D);
        check("mtlo hi_kept", 64'(bus.hi), 64'h0000_0000_DEAD_BEEF);
        check("mtlo busy", 64'(bus.busy), 64'd0);
        check("mtlo done", 64'(bus.done), 64'd0);

        // MTHI poked mid-RUN must not touch HI.
        do_op("multu_max", MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 5, MTHI);
        @(posedge clk); #1;
        check("multu_max done_pulse_width", 64'(bus.done), 64'd0);

        do_op("mult_neg7x6", MULT, 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 0, MULT);
        do_op("mult_min_sq", MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 0, MULT);

        // MULTU poked mid-RUN must be ignored.
        do_op("div_neg7_2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, MULTU);

        // Start in the DONE cycle is ignored; the next issue lands at E34.
        do_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 32, MULTU);
        do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, DIV);

        do_op("divu_by0", DIVU, 32'h0000_1234, 32'd0, 32'h0000_1234, 32'hFFFF_FFFF, 0, DIVU);

        // Asynchronous reset in the middle of RUN.
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.op    = MULTU;
        bus.a     = 32'h1234_5678;
        bus.b     = 32'd9;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_mid busy_before", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("rst_mid busy", 64'(bus.busy), 64'd0);
        check("rst_mid done", 64'(bus.done), 64'd0);
        check("rst_mid hi", 64'(bus.hi), 64'd0);
        check("rst_mid lo", 64'(bus.lo), 64'd0);
        #2;
        rst = 1'b0;
        @(posedge clk); #1;
        do_op("multu_3x5", MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 0, MULTU);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
